// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the single-port data memory: post-reset zero-fill sweep,
// round-robin grant, byte-enable merge via read-modify-write, registered response.
module dm_arbiter #(
    parameter int DEPTH        = 3072,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wd,
    input  logic [31:0] m0_pc,
    output logic        m0_ack,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wd,
    output logic        m1_ack,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd,
    output logic        busy,
    output logic        dbg_state,
    output logic        trace_valid,
    output logic [31:0] trace_pc
);
    // Handshake: a requester holds req (and its operands) until ack; ack is combinational
    // in the grant cycle, and rvalid follows exactly one cycle later for one cycle.
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] clr_cnt;
    logic          rr_ptr;
    logic          g0, g1;
    logic          s_we, s_err;
    logic [31:0]   s_addr, s_wd, merged, rdata_nxt;
    logic [3:0]    s_be;
    logic          m0_rv_q, m1_rv_q, m0_err_q, m1_err_q;
    logic [31:0]   m0_rdata_q, m1_rdata_q;

    function automatic logic access_err(input logic [31:0] addr, input logic [3:0] be);
        logic       legal;
        logic [1:0] low;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: legal = 1'b1;
            default:                   legal = 1'b0;
        endcase
        if (be[0])      low = 2'd0;
        else if (be[1]) low = 2'd1;
        else if (be[2]) low = 2'd2;
        else            low = 2'd3;
        return ({2'b00, addr[31:2]} >= 32'(DEPTH)) || !legal || (addr[1:0] != low);
    endfunction

    always_comb begin
        g0     = 1'b0;
        g1     = 1'b0;
        if (!rst && state == RUN) begin
            g0 = m0_req && (!m1_req || !rr_ptr);
            g1 = m1_req && !g0;
        end
        s_we   = g1 ? m1_we   : m0_we;
        s_addr = g1 ? m1_addr : m0_addr;
        s_be   = g1 ? m1_be   : m0_be;
        s_wd   = g1 ? m1_wd   : m0_wd;
        s_err  = access_err(s_addr, s_be);
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = s_be[i] ? s_wd[8*i +: 8] : mem_rd[8*i +: 8];
        end
        rdata_nxt = s_err ? 32'h0 : (s_we ? merged : mem_rd);
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {s_addr[31:2], 2'b00};
        mem_wd    = merged;
        case (state)
            CLEAR: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {{(30-CW){1'b0}}, clr_cnt, 2'b00};
                mem_wd   = 32'h0;
                if (clr_cnt == CW'(DEPTH - 1)) state_nxt = RUN;
            end
            RUN: mem_we = (g0 || g1) && s_we && !s_err;
            default: state_nxt = RUN;
        endcase
        if (rst) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLR_ON_RESET ? CLEAR : RUN;
            clr_cnt    <= '0;
            rr_ptr     <= 1'b0;
            m0_rv_q    <= 1'b0;
            m1_rv_q    <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m0_rdata_q <= 32'h0;
            m1_rdata_q <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
            if (g0)      rr_ptr <= 1'b1;
            else if (g1) rr_ptr <= 1'b0;
            m0_rv_q  <= g0;
            m1_rv_q  <= g1;
            m0_err_q <= g0 && s_err;
            m1_err_q <= g1 && s_err;
            if (g0) m0_rdata_q <= rdata_nxt;
            if (g1) m1_rdata_q <= rdata_nxt;
        end
    end

    // Gating rvalid with rst drops a response that was registered just before reset.
    assign m0_ack      = g0;
    assign m1_ack      = g1;
    assign m0_rvalid   = m0_rv_q && !rst;
    assign m1_rvalid   = m1_rv_q && !rst;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign m0_err      = m0_err_q;
    assign m1_err      = m1_err_q;
    assign dbg_state   = state;
    assign trace_valid = g0 && m0_we && !s_err;
    assign trace_pc    = m0_pc;
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Sequences and shares the single-port word-wide data memory between two requesters: M0 (CPU MEM stage) and M1 (DMA/debug port).
- Performs a zero-fill sweep of memory after reset.
- Arbitrates round-robin and merges byte-enabled partial stores into full-word writes, using the memory's combinational read (read-modify-write in one cycle).
- Range- and alignment-checks every request and returns a registered response one cycle after grant.

Parameters:
- DEPTH, 3072: number of 32-bit words in the memory. Word index is addr[31:2].
- CLR_ON_RESET, 1: 1 = run the zero-fill sweep after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- m0_req  in  1  M0 request, held until m0_ack
- m0_we  in  1  M0 write (1) / read (0)
- m0_addr  in  32  M0 byte address
- m0_be  in  4  M0 byte enables, lane i = bits [8i+7:8i]
- m0_wd  in  32  M0 write data, lane-positioned
- m0_pc  in  32  PC of the M0 instruction, used for the commit trace
- m0_ack  out  1  M0 grant, combinational
- m0_rvalid  out  1  M0 response valid, registered
- m0_rdata  out  32  M0 response data
- m0_err  out  1  M0 response error
- m1_req, m1_we, m1_addr, m1_be, m1_wd, m1_ack, m1_rvalid, m1_rdata, m1_err: same as M0 (no pc input)
- mem_addr  out  32  word-aligned byte address to memory
- mem_wd  out  32  write word to memory
- mem_we  out  1  memory write strobe
- mem_rd  in  32  combinational read data of mem_addr
- busy  out  1  high during CLEAR

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk.
- While rst=1, acks and mem_we are forced 0.
- On a clk edge with rst=1:
  - state <= CLEAR (RUN if CLR_ON_RESET=0)
  - clr_cnt <= 0
  - rr_ptr <= 0 (M0 favoured)
  - m*_rvalid, m*_rdata, m*_err <= 0
- Reset takes effect mid-operation too: any in-flight response is dropped, and a sweep restarts from word 0.
- CLEAR state:
  - Each cycle: mem_we=1, mem_addr=clr_cnt<<2, mem_wd=0, clr_cnt++.
  - After writing word DEPTH-1, go to RUN; CLEAR lasts exactly DEPTH cycles.
  - busy=1 and both acks=0 throughout; requests are held, not lost.
- RUN arbitration, one transaction per cycle:
  - Only one req asserted: grant it.
  - Both asserted: grant M0 if rr_ptr=0, else M1.
  - After any grant, rr_ptr <= index of the non-granted requester. Back-to-back contention therefore alternates M0, M1, M0, …
  - ack is asserted only for the granted requester.
- Granted access:
  - mem_addr = {addr[31:2],2'b00}.
  - Legal be patterns: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - err = (addr[31:2] >= DEPTH) OR be not legal OR addr[1:0] does not equal the lowest set be lane (lowest set lane must equal addr[1:0]).
  - Write with err=0: mem_we=1; mem_wd lane i = be[i] ? wd lane i : mem_rd lane i.
  - Write with err=1: mem_we=0; memory unchanged.
  - On an M0 write commit, print "@<m0_pc>: *<m0_addr> <= <mem_wd>" (%h, 8 digits). M1 writes do not print.
- Response, registered on the next edge:
  - Granted requester: rvalid=1 for exactly one cycle; err as computed.
  - rdata = mem_rd for a read, merged word for a write, 0 when err=1.
  - Non-granted requester: rvalid=0.
- Throughput: a requester holding req continuously with no contention is acked every cycle. Responses are pipelined one cycle behind acks.
- An ungranted requester is acked on the cycle contention ends, or at latest the next cycle under round-robin (no starvation).

Test Plan:
- Sweep: rst 1 cycle with DEPTH=8 → busy=1 and mem_we=1 for 8 cycles at addresses 0x00..0x1C, data 0; m0_req held throughout gets its first ack on cycle 9.
- Partial store: word 0x10 holds 0x11223344; M0 write addr 0x12, be 1100, wd 0xAABB0000 → mem_wd 0xAABB3344; next cycle m0_rvalid=1, m0_rdata=0xAABB3344, err=0; trace line printed.
- Contention: both req held for 4 cycles → acks M0, M1, M0, M1; each rvalid follows its ack by 1 cycle.
- Errors: M1 read addr DEPTH*4 → m1_err=1, rdata 0. M0 write addr 0x01, be 0011 → m0_err=1, mem_we=0, word unchanged.
- Reset mid-op: rst asserted in the cycle after an M0 ack → no m0_rvalid; CLEAR restarts at word 0.
- CLR_ON_RESET=0: after rst, a read at 0x0 is acked in the first cycle following reset release.
